// File: rtl/mem_access_unit.sv
// Arbitrates RV32I fetch and load/store onto one memory port: one access per three cycles.
// Define MEMACC_ROUND_ROBIN_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_access_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] if_instr_addr_q, if_instr_addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        src_ls_q, src_ls_d;
    logic        err_q, err_d;

    logic        any_req;
    logic        grant_ls;
    logic [2:0]  sel_funct3;
    logic [31:0] sel_addr;
    logic        misaligned;
    logic        in_resp;

`ifdef MEMACC_ROUND_ROBIN_EN
    logic last_ls_q, last_ls_d;

    // On a tie, serve whichever source lost the previous grant.
    assign grant_ls = ls_req && (!if_req || !last_ls_q);

    always_comb begin
        last_ls_d = last_ls_q;
        if (state_q == StIdle && any_req) begin
            last_ls_d = grant_ls;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    assign grant_ls = ls_req;
`endif

    assign any_req    = if_req || ls_req;
    assign sel_funct3 = grant_ls ? ls_funct3 : 3'b010;
    assign sel_addr   = grant_ls ? ls_addr : if_addr;
    assign misaligned = ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                        ((sel_funct3[1:0] == 2'b01) && sel_addr[0]);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        if_instr_addr_d = if_instr_addr_q;
        funct3_d        = funct3_q;
        we_d            = we_q;
        src_ls_d        = src_ls_q;
        err_d           = err_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    addr_d   = sel_addr;
                    funct3_d = sel_funct3;
                    we_d     = grant_ls && ls_we;
                    wdata_d  = grant_ls ? ls_wdata : 32'd0;
                    src_ls_d = grant_ls;
                    err_d    = misaligned;
                    rdata_d  = 32'd0;
                    if (!grant_ls) begin
                        if_instr_addr_d = if_addr;
                    end
                    // Misaligned accesses skip memory entirely so a bad store has no effect.
                    state_d = misaligned ? StResp : StAccess;
                end
            end
            StAccess: begin
                rdata_d = we_q ? 32'd0 : mem_read_data;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            addr_q          <= 32'd0;
            wdata_q         <= 32'd0;
            rdata_q         <= 32'd0;
            if_instr_addr_q <= RESET_PC;
            funct3_q        <= 3'b010;
            we_q            <= 1'b0;
            src_ls_q        <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            if_instr_addr_q <= if_instr_addr_d;
            funct3_q        <= funct3_d;
            we_q            <= we_d;
            src_ls_q        <= src_ls_d;
            err_q           <= err_d;
        end
    end

    // Memory pins are decoded from state so an async reset aborts a store at once.
    always_comb begin
        mem_write_mem     = 1'b0;
        mem_funct3        = 3'b010;
        mem_write_address = 32'd0;
        mem_write_data    = 32'd0;
        mem_read_address  = 32'd0;
        if (state_q == StAccess) begin
            mem_write_mem     = we_q;
            mem_funct3        = funct3_q;
            mem_write_address = addr_q;
            mem_write_data    = wdata_q;
            mem_read_address  = addr_q;
        end
    end

    assign in_resp  = (state_q == StResp);
    assign if_ready = in_resp && !src_ls_q;
    assign ls_ready = in_resp && src_ls_q;
    assign if_err   = if_ready && err_q;
    assign ls_err   = ls_ready && err_q;
    assign if_rdata = (if_ready && !err_q) ? rdata_q : 32'd0;
    assign ls_rdata = (ls_ready && !err_q) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RV32I memory (comb read, clocked write).
module tb_mem_access_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_ready, ls_err;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          wr_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] rd_word;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;

    mem_access_unit #(.RESET_PC(RstPc)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_ready          (if_ready),
        .if_rdata          (if_rdata),
        .if_err            (if_err),
        .ls_req            (ls_req),
        .ls_we             (ls_we),
        .ls_funct3         (ls_funct3),
        .ls_addr           (ls_addr),
        .ls_wdata          (ls_wdata),
        .ls_ready          (ls_ready),
        .ls_rdata          (ls_rdata),
        .ls_err            (ls_err),
        .mem_write_mem     (mem_write_mem),
        .mem_funct3        (mem_funct3),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        rd_word = mem[mem_read_address[9:2]];
        rd_b    = 8'(rd_word >> {mem_read_address[1:0], 3'b000});
        rd_h    = 16'(rd_word >> {mem_read_address[1], 4'b0000});
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{rd_b[7]}}, rd_b};
            3'b001:  mem_read_data = {{16{rd_h[15]}}, rd_h};
            3'b100:  mem_read_data = {24'd0, rd_b};
            3'b101:  mem_read_data = {16'd0, rd_h};
            default: mem_read_data = rd_word;
        endcase
    end

    always @(posedge clk) begin
        logic [7:0] idx;
        logic [4:0] sh;
        idx = mem_write_address[9:2];
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_write_mem) begin
            wr_cnt <= wr_cnt + 1;
            case (mem_funct3[1:0])
                2'b00: begin
                    sh = {mem_write_address[1:0], 3'b000};
                    mem[idx] <= (mem[idx] & ~(32'h0000_00FF << sh)) |
                                ({24'd0, mem_write_data[7:0]} << sh);
                end
                2'b01: begin
                    sh = {mem_write_address[1], 4'b0000};
                    mem[idx] <= (mem[idx] & ~(32'h0000_FFFF << sh)) |
                                ({16'd0, mem_write_data[15:0]} << sh);
                end
                default: mem[idx] <= mem_write_data;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // Issue one request, hold it until ready, then drop it in the ready cycle.
    task automatic access(input string tag, input bit is_ls, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_wr);
        int n;
        int wr0;
        wr0 = wr_cnt;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 1;
        while (!(is_ls ? ls_ready : if_ready) && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_rdata"}, is_ls ? ls_rdata : if_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, is_ls ? ls_err : if_err}, {31'd0, exp_err});
        check({tag, "_other_rdy"}, {31'd0, is_ls ? if_ready : ls_ready}, 32'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        check({tag, "_rdy_pulse"}, {30'd0, if_ready, ls_ready}, 32'd0);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        logic [2:0] exp_grant;
        int n;
`ifdef MEMACC_ROUND_ROBIN_EN
        exp_grant = 3'b101;
`else
        exp_grant = 3'b111;
`endif
        reset = 1'b1;
        pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'd0; ls_wdata = 32'd0;
        for (int i = 0; i < 256; i++) preload(8'(i), 32'd0);
        preload(8'd4, 32'h0050_0093);
        preload(8'd16, 32'hCAFE_F00D);
        reset = 1'b0;
        tick();

        check("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_mem}, 32'd0);
        check("rst_mem_f3", {29'd0, mem_funct3}, 32'd2);
        check("rst_mem_addr", mem_read_address | mem_write_address | mem_write_data, 32'd0);
        check("rst_pc", dut.if_instr_addr_q, RstPc);

        access("fetch", 1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 3, 32'h0050_0093, 1'b0, 0);
        check("fetch_pc", dut.if_instr_addr_q, 32'h10);
        access("fetch_mis", 1'b0, 1'b0, 3'b010, 32'h12, 32'd0, 2, 32'd0, 1'b1, 0);
        access("sw", 1'b1, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 3, 32'd0, 1'b0, 1);
        check("sw_mem", mem[8], 32'hDEAD_BEEF);
        access("lb", 1'b1, 1'b0, 3'b000, 32'h23, 32'd0, 3, 32'hFFFF_FFDE, 1'b0, 0);
        access("lbu", 1'b1, 1'b0, 3'b100, 32'h23, 32'd0, 3, 32'h0000_00DE, 1'b0, 0);
        access("lh", 1'b1, 1'b0, 3'b001, 32'h22, 32'd0, 3, 32'hFFFF_DEAD, 1'b0, 0);
        access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h21, 32'd0, 2, 32'd0, 1'b1, 0);
        access("sw_mis", 1'b1, 1'b1, 3'b010, 32'h22, 32'h1111_1111, 2, 32'd0, 1'b1, 0);
        check("sw_mis_mem", mem[8], 32'hDEAD_BEEF);
        access("sb", 1'b1, 1'b1, 3'b000, 32'h21, 32'h0000_0055, 3, 32'd0, 1'b0, 1);
        check("sb_mem", mem[8], 32'hDEAD_55EF);
        access("sw_top", 1'b1, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h00FF_0080, 3, 32'd0, 1'b0, 1);
        access("lw_top", 1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 3, 32'h00FF_0080, 1'b0, 0);

        // Reset in the middle of a store's memory cycle.
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h40; ls_wdata = 32'h1234;
        tick();
        check("abort_we_before", {31'd0, mem_write_mem}, 32'd1);
        check("abort_addr_before", mem_write_address, 32'h40);
        #1 reset = 1'b1;
        #1;
        check("abort_we_now", {31'd0, mem_write_mem}, 32'd0);
        check("abort_addr_now", mem_write_address, 32'd0);
        ls_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("abort_mem", mem[16], 32'hCAFE_F00D);
        check("abort_pc", dut.if_instr_addr_q, RstPc);
        check("abort_rdy", {30'd0, if_ready, ls_ready}, 32'd0);

        // Both sources request continuously; each ready is followed by a fresh request.
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h20;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!(if_ready || ls_ready) && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("arb_grant%0d", k), {31'd0, ls_ready}, {31'd0, exp_grant[2-k]});
            check($sformatf("arb_lat%0d", k), 32'(n), 32'd2);
            if (k == 2) ls_req = 1'b0;
            tick();
        end
        n = 0;
        while (!if_ready && n < 10) begin
            tick();
            n++;
        end
        check("arb_if_served", {31'd0, if_ready}, 32'd1);
        check("arb_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        tick();

        access("lw_after_abort", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 3, 32'hCAFE_F00D, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
